// File: rtl/pattern_sequencer.sv
// VGA frame sequencer: pixel/line counters, registered sync and colour, and a
// once-per-frame source selector driven by auto-cycling or by user requests.
module pattern_sequencer #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int FRAMES_PER_SRC = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        auto_en,
  input  logic        next_req,
  input  logic [47:0] src_rgb,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [1:0]  src_sel,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam int CW = (FRAMES_PER_SRC > 1) ? $clog2(FRAMES_PER_SRC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_SRC - 1);

  logic [CW-1:0] frame_cnt;
  logic          pending;
  logic          boundary;
  logic          req_now;
  logic          auto_adv;
  logic          advance;
  logic          active;
  logic          in_hsync;
  logic          in_vsync;
  logic [11:0]   src_pix;

  // A request arriving on the boundary cycle itself is folded in via req_now.
  always_comb begin
    boundary = 1'b0;
    req_now  = 1'b0;
    auto_adv = 1'b0;
    advance  = 1'b0;
    active   = 1'b0;
    in_hsync = 1'b0;
    in_vsync = 1'b0;
    src_pix  = 12'h000;

    boundary = pix_en && (x == X_LAST) && (y == Y_LAST);
    req_now  = pending || next_req;
    auto_adv = auto_en && (frame_cnt == CNT_LAST);
    advance  = boundary && (req_now || auto_adv);
    active   = (x < X_ACT) && (y < Y_ACT);
    in_hsync = (x >= HS_START) && (x < HS_END);
    in_vsync = (y >= VS_START) && (y < VS_END);

    case (src_sel)
      2'd0:    src_pix = src_rgb[11:0];
      2'd1:    src_pix = src_rgb[23:12];
      2'd2:    src_pix = src_rgb[35:24];
      default: src_pix = src_rgb[47:36];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= 10'd0;
      y <= 10'd0;
    end else if (pix_en) begin
      if (x == X_LAST) begin
        x <= 10'd0;
        y <= (y == Y_LAST) ? 10'd0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  // Outputs are computed from the pre-increment coordinates so that sync and
  // colour stay aligned one pixel step behind x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
      red     <= 4'h0;
      green   <= 4'h0;
      blue    <= 4'h0;
    end else if (pix_en) begin
      hsync_n <= !in_hsync;
      vsync_n <= !in_vsync;
      {red, green, blue} <= active ? src_pix : 12'h000;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      pending     <= 1'b0;
      frame_cnt   <= '0;
      src_sel     <= 2'd0;
    end else begin
      frame_start <= boundary;
      pending     <= boundary ? 1'b0 : req_now;
      if (!auto_en) begin
        frame_cnt <= '0;
      end else if (boundary) begin
        frame_cnt <= (req_now || auto_adv) ? '0 : frame_cnt + CW'(1);
      end
      if (advance) begin
        src_sel <= src_sel + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer using a shrunken raster, a vector
// table, directed frame-boundary sequences and a randomized phase.
module tb_pattern_sequencer;

  localparam int HA    = 8;
  localparam int HFP   = 2;
  localparam int HS    = 3;
  localparam int HBP   = 2;
  localparam int VA    = 6;
  localparam int VFP   = 1;
  localparam int VS    = 2;
  localparam int VBP   = 1;
  localparam int FPS   = 2;
  localparam int HT    = HA + HFP + HS + HBP;
  localparam int VT    = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pix_en = 1'b0;
  logic        auto_en = 1'b0;
  logic        next_req = 1'b0;
  logic [47:0] src_rgb = '0;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        hsync_n;
  logic        vsync_n;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic [1:0]  src_sel;
  logic        frame_start;

  always #5 clk = ~clk;

  pattern_sequencer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FRAMES_PER_SRC(FPS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .auto_en(auto_en),
    .next_req(next_req), .src_rgb(src_rgb), .x(x), .y(y),
    .hsync_n(hsync_n), .vsync_n(vsync_n), .red(red), .green(green),
    .blue(blue), .src_sel(src_sel), .frame_start(frame_start)
  );

  int nChecks = 0;
  int nFail   = 0;

  // Reference model: a linear pixel index within the frame plus frame-level
  // bookkeeping for which source is on screen.
  int mPos;
  int mSel;
  int mShown;
  bit mPend;
  int mRgb;
  bit mHs;
  bit mVs;
  bit mFs;

  typedef struct {
    bit pe;
    int expX;
    int expRgb;
  } vec_t;

  vec_t vecs[6];

  function automatic int srcColor(int s);
    logic [47:0] sh;
    sh = src_rgb >> (12 * s);
    return int'(sh[11:0]);
  endfunction

  task automatic modelReset();
    mPos = 0; mSel = 0; mShown = 0; mPend = 0;
    mRgb = 0; mHs = 1; mVs = 1; mFs = 0;
  endtask

  task automatic modelStep(bit pe, bit ae, bit rq);
    bit bnd;
    bit want;
    bit autoFire;
    int px;
    int py;
    bnd  = pe && (mPos == FRAME - 1);
    want = mPend || rq;
    mFs  = bnd;
    if (pe) begin
      px   = mPos % HT;
      py   = mPos / HT;
      mRgb = (px < HA && py < VA) ? srcColor(mSel) : 0;
      mHs  = !(px >= HA + HFP && px < HA + HFP + HS);
      mVs  = !(py >= VA + VFP && py < VA + VFP + VS);
      mPos = (mPos + 1) % FRAME;
    end
    if (bnd) begin
      autoFire = ae && (mShown + 1 == FPS);
      if (want || autoFire) begin
        mSel   = (mSel + 1) % 4;
        mShown = 0;
      end else begin
        mShown = ae ? mShown + 1 : 0;
      end
      mPend = 0;
    end else begin
      mPend = want;
      if (!ae) mShown = 0;
    end
  endtask

  task automatic checkVal(string name, int act, int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkVal("x", int'(x), mPos % HT);
    checkVal("y", int'(y), mPos / HT);
    checkVal("hsync_n", int'(hsync_n), int'(mHs));
    checkVal("vsync_n", int'(vsync_n), int'(mVs));
    checkVal("rgb", int'({red, green, blue}), mRgb);
    checkVal("src_sel", int'(src_sel), mSel);
    checkVal("frame_start", int'(frame_start), int'(mFs));
  endtask

  task automatic applyStimulus(bit pe, bit ae, bit rq);
    pix_en   = pe;
    auto_en  = ae;
    next_req = rq;
    @(posedge clk);
    modelStep(pe, ae, rq);
    #1;
    checkOutput();
    next_req = 1'b0;
  endtask

  task automatic doReset(int holdCycles);
    pix_en   = 1'b0;
    next_req = 1'b0;
    rst_n    = 1'b0;
    #1;
    modelReset();
    checkOutput();
    repeat (holdCycles) @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;
  endtask

  task automatic runTo(int target, bit ae);
    for (int i = 0; i < 2 * FRAME && mPos != target; i++) applyStimulus(1'b1, ae, 1'b0);
    if (mPos != target) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL runTo timeout: actual=%0d expected=%0d", mPos, target);
    end
  endtask

  task automatic boundaryStep(bit ae, bit rq);
    runTo(FRAME - 1, ae);
    applyStimulus(1'b1, ae, rq);
  endtask

  initial begin
    int selA;
    src_rgb = {12'hF00, 12'h0F0, 12'h00F, 12'hFFF};
    #2;
    doReset(2);

    // Stall behaviour and one-step output latency after reset.
    vecs[0] = '{1'b1, 1, 12'hFFF};
    vecs[1] = '{1'b0, 1, 12'hFFF};
    vecs[2] = '{1'b1, 2, 12'hFFF};
    vecs[3] = '{1'b1, 3, 12'hFFF};
    vecs[4] = '{1'b0, 3, 12'hFFF};
    vecs[5] = '{1'b1, 4, 12'hFFF};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].pe, 1'b0, 1'b0);
      checkVal("vecX", int'(x), vecs[i].expX);
      checkVal("vecY", int'(y), 0);
      checkVal("vecRgb", int'({red, green, blue}), vecs[i].expRgb);
    end

    // Several mid-frame requests collapse to a single advance at the boundary.
    runTo(30, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runTo(60, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkVal("selMidFrame", int'(src_sel), 0);
    boundaryStep(1'b0, 1'b0);
    checkVal("manualAdvance", int'(src_sel), 1);
    checkVal("frameStartPulse", int'(frame_start), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkVal("frameStartOneClk", int'(frame_start), 0);
    checkVal("selHeld", int'(src_sel), 1);

    boundaryStep(1'b0, 1'b1);
    checkVal("reqOnBoundary", int'(src_sel), 2);

    for (int k = 0; k < 4; k++) begin
      runTo(70, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      boundaryStep(1'b0, 1'b0);
      checkVal("singleReqSeq", int'(src_sel), (3 + k) % 4);
    end

    // Auto mode with two frames per source, then a coinciding request.
    selA = mSel;
    boundaryStep(1'b1, 1'b0);
    checkVal("autoHold", int'(src_sel), selA);
    boundaryStep(1'b1, 1'b0);
    checkVal("autoAdvance", int'(src_sel), (selA + 1) % 4);
    boundaryStep(1'b1, 1'b0);
    boundaryStep(1'b1, 1'b1);
    checkVal("autoPlusReq", int'(src_sel), (selA + 2) % 4);
    boundaryStep(1'b1, 1'b0);
    checkVal("counterRestart", int'(src_sel), (selA + 2) % 4);
    boundaryStep(1'b1, 1'b0);
    checkVal("autoAfterRestart", int'(src_sel), (selA + 3) % 4);

    // Dropping auto_en mid-frame discards the partial frame count.
    boundaryStep(1'b1, 1'b0);
    runTo(40, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    boundaryStep(1'b1, 1'b0);
    checkVal("autoEnClear", int'(src_sel), (selA + 3) % 4);

    // Async reset mid-frame with source 2 selected and a request pending.
    for (int k = 0; k < 4 && mSel != 2; k++) boundaryStep(1'b0, 1'b1);
    checkVal("selBeforeReset", int'(src_sel), 2);
    runTo(4 * HT + 5, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    doReset(1);
    checkVal("rstX", int'(x), 0);
    checkVal("rstSel", int'(src_sel), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkVal("rstNoAdvanceIdle", int'(x), 0);
    boundaryStep(1'b0, 1'b0);
    checkVal("pendingCleared", int'(src_sel), 0);

    // Randomized phase against the reference model.
    begin
      bit ae;
      ae = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 499) == 0) ae = !ae;
        if ($urandom_range(0, 49) == 0) src_rgb = {$urandom(), $urandom()};
        applyStimulus($urandom_range(0, 3) != 0, ae, $urandom_range(0, 199) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
VGA frame sequencer and source scheduler for the display path. It generates the pixel coordinates and sync timing. It drives x/y to up to four 12-bit RGB pattern sources, such as the checker background and the game layer. Once per frame it selects which source reaches the screen, either by auto-cycling or on request. Sits between the pixel-clock enable and the VGA pins; outputs are registered and pixel-aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
FRAMES_PER_SRC, 60, frames each source is shown in auto mode (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel tick; all state advances only when high
auto_en  in  1  1 = auto-cycle sources every FRAMES_PER_SRC frames
next_req  in  1  single-cycle request to advance source at next frame boundary
src_rgb  in  48  four sources, {r,g,b} 4b each; source i at bits [12i+11:12i]; combinational from x/y
x  out  10  current column counter, 0..H_TOTAL-1
y  out  10  current line counter, 0..V_TOTAL-1
hsync_n  out  1  registered, active-low
vsync_n  out  1  registered, active-low
red, green, blue  out  4 each  registered pixel colour
src_sel  out  2  currently displayed source index
frame_start  out  1  one-clk pulse on frame wrap

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (async, on rst_n low): all of the following reset immediately, independent of clk:
  - x = 0, y = 0
  - hsync_n = 1, vsync_n = 1
  - red = green = blue = 0
  - src_sel = 0, frame_start = 0
  - frame counter = 0, pending request = 0
- Reset mid-frame aborts the frame. Counting restarts at (0,0) on the first pix_en after release.
- Counters (on pix_en):
  - x increments and wraps H_TOTAL-1 -> 0.
  - On the x wrap, y increments and wraps V_TOTAL-1 -> 0.
  - No change when pix_en = 0.
- Frame boundary: pix_en && x == H_TOTAL-1 && y == V_TOTAL-1.
  - frame_start is registered high for exactly the following clk cycle, whatever pix_en is on that cycle.
- Pipeline: latency is one pix_en step from x/y to the outputs.
  - On each pix_en, with the pre-increment x/y, register:
    - active = (x < H_ACTIVE) && (y < V_ACTIVE)
    - rgb = active ? src_rgb[src_sel] : 12'h000
    - hsync_n = !(x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. low for x = 656..751
    - vsync_n = !(y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. low for y = 490..491
  - Sync outputs and colour are therefore mutually aligned.
- Request latch:
  - next_req sets a sticky pending bit on any clk, regardless of pix_en.
  - Pending clears at the frame boundary.
  - Multiple requests within one frame collapse to one advance.
  - A request on the boundary cycle itself counts toward that boundary.
- Frame counter:
  - Held at 0 while auto_en = 0.
  - When auto_en = 1, it increments at each boundary.
  - At a boundary where it equals FRAMES_PER_SRC-1, it clears to 0 and an auto-advance fires.
- Source advance:
  - Occurs only at a frame boundary, if pending OR auto-advance.
  - src_sel = src_sel + 1, mod 4 (3 -> 0).
  - If both pending and auto-advance hold at the same boundary, advance by exactly one; pending and the counter both clear.
  - Any request-triggered advance also clears the frame counter.
- src_sel therefore never changes mid-frame, and no frame shows mixed sources.
- Deasserting auto_en mid-frame clears the frame counter on the next clk.

Test Plan:
- Reset then pix_en every cycle -> x/y sequence (0,0),(1,0)…(799,0),(0,1); frame_start pulses after (799,524); all outputs 0/idle during reset.
- Sync timing: count pix_en with hsync_n = 0 -> 96 per line, starting when registered x = 657 (output of x = 656); vsync_n low for exactly 2 lines (y = 490,491); red/green/blue = 0 for every x >= 640 or y >= 480.
- Source routing: src_rgb = {12'hF00, 12'h0F0, 12'h00F, 12'hFFF}, src_sel = 0 -> visible pixels = 12'hFFF; pix_en toggling 1/0 -> counters stall on 0 cycles, output latency still one pix_en step.
- Manual: auto_en = 0, three next_req pulses mid-frame -> src_sel 0 -> 1 only at the next boundary; a req at (799,524) advances at that boundary; 4 single requests in 4 frames -> 0,1,2,3,0.
- Auto with FRAMES_PER_SRC = 2: src_sel changes every 2 frames; next_req coinciding with auto boundary -> advance by exactly 1 and frame counter restarts.
- Async reset asserted at (300,200) with src_sel = 2 -> immediate outputs 0, src_sel = 0, pending cleared; restart from (0,0).
